// File: rtl/flag_file_forward_unit.sv
// Carry/zero flag file for the pipelined CPU: tracks flag writers between EX and
// commit, forwards the youngest valid pair into EX, and stalls ID behind late producers.
module flag_file_forward_unit #(
  parameter int unsigned           OPW        = 3,
  parameter logic [OPW-1:0]        CONSUME_OP = 3'b101
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           ex_valid,
  input  logic           ex_change_carry_zero,
  input  logic           ex_late,
  input  logic           ex_carry,
  input  logic           ex_zero,
  input  logic           mem_carry,
  input  logic           mem_zero,
  input  logic           id_valid,
  input  logic [OPW-1:0] id_inst,
  input  logic           flush,
  output logic           stall,
  output logic           carry_in_ex,
  output logic           zero_in_ex,
  output logic [1:0]     fwd_sel,
  output logic           arch_carry,
  output logic           arch_zero,
  output logic [1:0]     pending_cnt
);

  localparam logic [1:0] SEL_ARCH = 2'b00;
  localparam logic [1:0] SEL_S2   = 2'b01;
  localparam logic [1:0] SEL_S1   = 2'b10;

  // S1 = instruction in MEM, S2 = instruction in WB.
  logic v1, late1, c1, z1;
  logic v2, c2, z2;

  logic ex_writes_flags;
  logic s1_carry, s1_zero;

  assign ex_writes_flags = ex_valid & ex_change_carry_zero;

  // A late producer's flags only exist on the mem_* inputs while it sits in MEM.
  assign s1_carry = late1 ? mem_carry : c1;
  assign s1_zero  = late1 ? mem_zero  : z1;

  // NOTE: state uses non-blocking assignments so every register samples the
  // pre-edge values of the others; that is what makes S1 -> S2 -> arch shift.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v1         <= 1'b0;
      late1      <= 1'b0;
      c1         <= 1'b0;
      z1         <= 1'b0;
      v2         <= 1'b0;
      c2         <= 1'b0;
      z2         <= 1'b0;
      arch_carry <= 1'b0;
      arch_zero  <= 1'b0;
    end else begin
      v1    <= ex_writes_flags & ~flush;
      late1 <= ex_late;
      c1    <= ex_carry;
      z1    <= ex_zero;

      v2 <= v1;
      c2 <= s1_carry;
      z2 <= s1_zero;

      if (v2) begin
        arch_carry <= c2;
        arch_zero  <= z2;
      end
    end
  end

  // NOTE: every output of this block is given a default first, so no path
  // through the if/else chain can leave a value held (no latch is inferred).
  always_comb begin
    fwd_sel     = SEL_ARCH;
    carry_in_ex = arch_carry;
    zero_in_ex  = arch_zero;
    if (v1) begin
      fwd_sel     = SEL_S1;
      carry_in_ex = s1_carry;
      zero_in_ex  = s1_zero;
    end else if (v2) begin
      fwd_sel     = SEL_S2;
      carry_in_ex = c2;
      zero_in_ex  = z2;
    end
  end

  // One bubble suffices: next cycle the producer is in MEM and EX holds the bubble.
  assign stall = id_valid & (id_inst == CONSUME_OP) & ex_writes_flags & ex_late & ~flush;

  assign pending_cnt = {1'b0, v1} + {1'b0, v2};

endmodule

// File: tb/tb_flag_file_forward_unit.sv
// Directed bench for flag_file_forward_unit: reset, normal/late producers,
// forwarding priority, flush and non-consumer stall behaviour.
module tb_flag_file_forward_unit;

  logic       clk = 1'b0;
  logic       rst;
  logic       ex_valid, ex_change_carry_zero, ex_late, ex_carry, ex_zero;
  logic       mem_carry, mem_zero;
  logic       id_valid;
  logic [2:0] id_inst;
  logic       flush;
  logic       stall, carry_in_ex, zero_in_ex, arch_carry, arch_zero;
  logic [1:0] fwd_sel, pending_cnt;

  int n_checks = 0;
  int n_pass   = 0;
  int n_fail   = 0;

  flag_file_forward_unit #(.OPW(3), .CONSUME_OP(3'b101)) dut (
    .clk                  (clk),
    .rst                  (rst),
    .ex_valid             (ex_valid),
    .ex_change_carry_zero (ex_change_carry_zero),
    .ex_late              (ex_late),
    .ex_carry             (ex_carry),
    .ex_zero              (ex_zero),
    .mem_carry            (mem_carry),
    .mem_zero             (mem_zero),
    .id_valid             (id_valid),
    .id_inst              (id_inst),
    .flush                (flush),
    .stall                (stall),
    .carry_in_ex          (carry_in_ex),
    .zero_in_ex           (zero_in_ex),
    .fwd_sel              (fwd_sel),
    .arch_carry           (arch_carry),
    .arch_zero            (arch_zero),
    .pending_cnt          (pending_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    ex_valid = 0; ex_change_carry_zero = 0; ex_late = 0; ex_carry = 0; ex_zero = 0;
    mem_carry = 0; mem_zero = 0; id_valid = 0; id_inst = 3'b000; flush = 0;
  endtask

  // Drive a flag producer into EX.
  task automatic producer(input logic late, input logic c, input logic z);
    ex_valid = 1; ex_change_carry_zero = 1; ex_late = late; ex_carry = c; ex_zero = z;
  endtask

  // Drive a non-writing instruction (e.g. a consumer) into EX.
  task automatic plain_ex();
    ex_valid = 1; ex_change_carry_zero = 0; ex_late = 0; ex_carry = 0; ex_zero = 0;
  endtask

  initial begin
    idle();
    rst = 1;
    tick(); tick();
    check("reset_stall", {3'b0, stall}, 4'h0);
    check("reset_fwd", {2'b0, fwd_sel}, 4'h0);
    check("reset_flags_ex", {2'b0, carry_in_ex, zero_in_ex}, 4'h0);
    check("reset_arch", {2'b0, arch_carry, arch_zero}, 4'h0);
    check("reset_pending", {2'b0, pending_cnt}, 4'h0);
    #2 rst = 0;

    // Normal producer {1,0}, consumer follows.
    tick();
    producer(0, 1, 0);
    tick();
    plain_ex(); #1;
    check("norm_fwd_s1", {2'b0, fwd_sel}, 4'h2);
    check("norm_flags_s1", {2'b0, carry_in_ex, zero_in_ex}, 4'h2);
    check("norm_pending1", {2'b0, pending_cnt}, 4'h1);
    tick();
    idle(); #1;
    check("norm_fwd_s2", {2'b0, fwd_sel}, 4'h1);
    tick();
    check("norm_arch", {2'b0, arch_carry, arch_zero}, 4'h2);
    check("norm_pending0", {2'b0, pending_cnt}, 4'h0);
    check("norm_fwd_arch", {2'b0, fwd_sel}, 4'h0);

    // Late producer with a consumer in ID.
    producer(1, 1, 1);
    id_valid = 1; id_inst = 3'b101; #1;
    check("late_stall", {3'b0, stall}, 4'h1);
    id_inst = 3'b010; #1;
    check("nonconsumer_stall", {3'b0, stall}, 4'h0);
    flush = 1; id_inst = 3'b101; #1;
    check("flush_kills_stall", {3'b0, stall}, 4'h0);
    flush = 0; #1;
    check("late_stall_again", {3'b0, stall}, 4'h1);
    tick();
    // Bubble in EX, consumer still held in ID, MEM resolves {0,1}.
    ex_valid = 0; ex_change_carry_zero = 0; ex_late = 0;
    mem_carry = 0; mem_zero = 1; #1;
    check("late_stall_one_cycle", {3'b0, stall}, 4'h0);
    check("late_fwd_s1", {2'b0, fwd_sel}, 4'h2);
    check("late_flags_mem", {2'b0, carry_in_ex, zero_in_ex}, 4'h1);
    tick();
    // Consumer in EX; mem_* now carries junk that must not be used.
    idle(); plain_ex(); mem_carry = 1; mem_zero = 0; #1;
    check("late_fwd_s2", {2'b0, fwd_sel}, 4'h1);
    check("late_flags_s2", {2'b0, carry_in_ex, zero_in_ex}, 4'h1);
    tick();
    idle(); #1;
    check("late_arch", {2'b0, arch_carry, arch_zero}, 4'h1);

    // Back-to-back producers A {1,1} then B {0,0}.
    producer(0, 1, 1);
    tick();
    producer(0, 0, 0); #1;
    check("prio_a_s1", {2'b0, carry_in_ex, zero_in_ex}, 4'h3);
    tick();
    plain_ex(); #1;
    check("prio_pending2", {2'b0, pending_cnt}, 4'h2);
    check("prio_fwd_s1", {2'b0, fwd_sel}, 4'h2);
    check("prio_flags_b", {2'b0, carry_in_ex, zero_in_ex}, 4'h0);
    tick();
    idle(); #1;
    check("prio_arch_a", {2'b0, arch_carry, arch_zero}, 4'h3);
    check("prio_fwd_s2", {2'b0, fwd_sel, carry_in_ex, zero_in_ex}, 4'h4);
    tick();
    check("prio_arch_b", {2'b0, arch_carry, arch_zero}, 4'h0);
    check("prio_pending0", {2'b0, pending_cnt}, 4'h0);

    // Flush: P {1,0} in S1, flushed late producer Q in EX with consumer in ID.
    producer(0, 1, 0);
    tick();
    producer(1, 0, 1); flush = 1; id_valid = 1; id_inst = 3'b101; #1;
    check("flush_stall", {3'b0, stall}, 4'h0);
    tick();
    idle(); #1;
    check("flush_pending", {2'b0, pending_cnt}, 4'h1);
    check("flush_fwd_s2", {2'b0, fwd_sel, carry_in_ex, zero_in_ex}, 4'h6);
    tick();
    plain_ex(); #1;
    check("flush_arch", {2'b0, arch_carry, arch_zero}, 4'h2);
    check("flush_fwd_arch", {2'b0, fwd_sel, carry_in_ex, zero_in_ex}, 4'h2);
    tick();

    // Asynchronous reset with S1 and S2 both valid.
    producer(0, 1, 1);
    tick();
    producer(0, 0, 1);
    tick();
    idle(); #1;
    check("pre_reset_pending", {2'b0, pending_cnt}, 4'h2);
    #1 rst = 1;
    #1;
    check("async_pending", {2'b0, pending_cnt}, 4'h0);
    check("async_fwd_flags", {fwd_sel, carry_in_ex, zero_in_ex}, 4'h0);
    check("async_arch", {2'b0, arch_carry, arch_zero}, 4'h0);
    #3 rst = 0;
    tick();
    check("post_reset", {fwd_sel, arch_carry, arch_zero}, 4'h0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/flag_file_forward_unit.md
Name: flag_file_forward_unit

Overview:
- Owns the architectural carry/zero flags of the pipelined CPU.
- Tracks in-flight flag-writing instructions between EX and commit (MEM = S1, WB = S2).
- Forwards the youngest valid flag pair into EX for flag-consuming instructions.
- Raises a one-cycle ID stall when a consumer directly follows a late (MEM-resolved) flag producer.

Parameters:
- CONSUME_OP, 3'b101: `inst` opcode that reads carry/zero in EX.
- OPW, 3: opcode width.

Ports:
- clk  in  1  pipeline clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- ex_valid  in  1  a real instruction occupies EX.
- ex_change_carry_zero  in  1  the EX instruction writes carry/zero.
- ex_late  in  1  the EX producer's flags resolve in MEM; ex_carry/ex_zero are ignored.
- ex_carry  in  1  carry result from the EX ALU.
- ex_zero  in  1  zero result from the EX ALU.
- mem_carry  in  1  carry resolved in MEM for a late producer.
- mem_zero  in  1  zero resolved in MEM for a late producer.
- id_valid  in  1  a real instruction occupies ID.
- id_inst  in  OPW  ID opcode.
- flush  in  1  kill the instructions in ID and EX this cycle.
- stall  out  1  hold PC/ID; the pipeline inserts a bubble into EX next cycle.
- carry_in_ex  out  1  carry operand delivered to EX.
- zero_in_ex  out  1  zero operand delivered to EX.
- fwd_sel  out  2  operand source: 00 arch, 01 S2, 10 S1.
- arch_carry  out  1  committed carry flag.
- arch_zero  out  1  committed zero flag.
- pending_cnt  out  2  number of valid flag writers in S1 + S2 (0..2).

Behaviour:
- State:
  - S1 = {v1, late1, c1, z1}
  - S2 = {v2, c2, z2}
  - arch = {arch_carry, arch_zero}
- Reset (async, rst=1): all state bits are 0, so stall=0, fwd_sel=00, carry_in_ex=0, zero_in_ex=0, pending_cnt=0. Reset mid-operation discards all in-flight updates immediately.
- Per rising clk edge (rst=0), all updates are simultaneous:
  - S1 <= {1, ex_late, ex_carry, ex_zero} if ex_valid & ex_change_carry_zero & !flush; otherwise v1 <= 0 and the other S1 bits are don't-care.
  - S2 <= {v1, late1 ? mem_carry : c1, late1 ? mem_zero : z1}. MEM resolution is captured here.
  - If v2, arch <= {c2, z2}; otherwise arch holds.
- Flush: suppresses only the S1 capture. S1 and S2 hold older instructions and always proceed to commit. A late producer in EX that is flushed never stalls a later consumer.
- Forwarding (combinational), youngest-first priority:
  - v1 & !late1: fwd_sel=10, flags = {c1, z1}.
  - v1 & late1: fwd_sel=10, flags = {mem_carry, mem_zero}. Only legal after a stall; see below.
  - else v2: fwd_sel=01, flags = {c2, z2}.
  - else: fwd_sel=00, flags = arch.
- Stall (combinational): stall = id_valid & (id_inst==CONSUME_OP) & ex_valid & ex_change_carry_zero & ex_late & !flush.
  - Exactly 1 cycle. The next cycle the producer is in S1 with late1=1 and the bubble is in EX.
  - The stall does not repeat because EX now holds the bubble.
  - During the stall the producer's S1 capture is unaffected.
- A consumer in EX never sees an unresolved value. Late data is forwarded from the mem_* inputs only while the producer sits in MEM.
- pending_cnt = v1 + v2.
- Back-to-back producers: each shifts independently. S1 always overrides S2, so a consumer sees the youngest producer.
- Non-consumer opcodes never stall, even behind a late producer.

Test Plan:
- Reset: drive rst=1 asynchronously mid-cycle with S1/S2 valid -> all outputs 0 immediately; after release, fwd_sel=00 and arch=00.
- Normal producer: EX producer with carry=1, zero=0, then a consumer in EX next cycle -> fwd_sel=10, carry_in_ex=1, zero_in_ex=0. After 2 more edges, arch_carry=1, arch_zero=0, pending_cnt=0.
- Late producer: late producer in EX with CONSUME_OP 3'b101 in ID -> stall=1 for exactly one cycle. Next cycle, with mem_carry=0, mem_zero=1 and the bubble in EX -> S2 captures {0,1}. When the consumer reaches EX -> fwd_sel=01, zero_in_ex=1.
- Priority: producer A {1,1} then producer B {0,0} back to back -> consumer sees fwd_sel=10 with {0,0}; arch ends at {0,0}; pending_cnt peaks at 2.
- Flush: flush=1 with a producer in EX and a consumer in ID -> stall=0, v1=0 next edge, older S2 still commits, and a later consumer sees fwd_sel=00.
- Non-consumer: late producer in EX with opcode 3'b010 in ID -> stall=0.
